imem_loader: RTL and testbench

- Program loader that drives the instruction memory's debug write port: enable_debug, debug_address, debug_inst_data1 and debug_inst_data2.
- Takes a byte stream from a host link (e.g. a UART receiver) over a valid/ready handshake.
- Assembles the bytes into 32-bit instructions and writes them two per write.
- Holds the core off instruction fetch while a load is in progress.

---
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Host-side byte link, load control and instruction-memory debug write port
// bundled for imem_loader. The master is the host/testbench side and the
// slave is the loader.
interface imem_loader_if #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
);
  logic                   start;
  logic [INS_ADDRESS:0]   num_words;
  logic [INS_ADDRESS-1:0] base_addr;
  logic                   s_valid;
  logic [7:0]             s_data;
  logic                   s_ready;
  logic                   enable_debug;
  logic [INS_ADDRESS-1:0] debug_address;
  logic [INS_W-1:0]       debug_inst_data1;
  logic [INS_W-1:0]       debug_inst_data2;
  logic                   busy;
  logic                   cpu_hold;
  logic                   done;

  modport master (
    output start, num_words, base_addr, s_valid, s_data,
    input  s_ready, enable_debug, debug_address, debug_inst_data1,
           debug_inst_data2, busy, cpu_hold, done
  );

  modport slave (
    input  start, num_words, base_addr, s_valid, s_data,
    output s_ready, enable_debug, debug_address, debug_inst_data1,
           debug_inst_data2, busy, cpu_hold, done
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit
// instructions and writes them in pairs through the instruction memory's
// debug write port, holding the core off fetch while the load runs.
module imem_loader #(
  parameter int               INS_ADDRESS  = 9,
  parameter int               INS_W        = 32,
  parameter int               ADDR_STEP    = 2,
  parameter int               WRITE_CYCLES = 2,
  parameter logic [INS_W-1:0] PAD_WORD     = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam int HOLD_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic                   wsel_q, wsel_d;
  logic [INS_ADDRESS:0]   words_left_q, words_left_d;
  logic [INS_ADDRESS-1:0] ptr_q, ptr_d;
  logic [INS_W-9:0]       part_q, part_d;
  logic [INS_W-1:0]       word_a_q, word_a_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   s_ready_q, s_ready_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [INS_ADDRESS-1:0] addr_q, addr_d;
  logic [INS_W-1:0]       data1_q, data1_d;
  logic [INS_W-1:0]       data2_q, data2_d;

  logic             xfer;
  logic             word_full;
  logic             last_word;
  logic             hold_end;
  logic [INS_W-1:0] new_word;

  // Newest byte lands in the top lane, so after four bytes byte 0 sits in [7:0].
  assign xfer      = bus.s_valid && s_ready_q;
  assign word_full = xfer && (byte_cnt_q == 2'd3);
  assign last_word = (words_left_q == {{INS_ADDRESS{1'b0}}, 1'b1});
  assign hold_end  = (hold_q == HOLD_W'(WRITE_CYCLES - 1));
  assign new_word  = {bus.s_data, part_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.num_words != '0) ? RECV : DONE;
      RECV:    if (word_full && (wsel_q || last_word)) state_d = WRITE;
      WRITE:   if (hold_end) state_d = (words_left_q != '0) ? RECV : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    wsel_d       = wsel_q;
    words_left_d = words_left_q;
    ptr_d        = ptr_q;
    part_d       = part_q;
    word_a_d     = word_a_q;
    hold_d       = hold_q;
    s_ready_d    = s_ready_q;
    enable_d     = enable_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    addr_d       = addr_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_words != '0) begin
            words_left_d = bus.num_words;
            ptr_d        = bus.base_addr;
            byte_cnt_d   = 2'd0;
            wsel_d       = 1'b0;
            busy_d       = 1'b1;
            s_ready_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (xfer) begin
          part_d     = new_word[INS_W-1:8];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_full) begin
            words_left_d = words_left_q - 1'b1;
            if (!wsel_q && !last_word) begin
              word_a_d = new_word;
              wsel_d   = 1'b1;
            end else begin
              // Address and both data words move together on WRITE entry.
              addr_d    = ptr_q;
              data1_d   = wsel_q ? word_a_q : new_word;
              data2_d   = wsel_q ? new_word : PAD_WORD;
              enable_d  = 1'b1;
              s_ready_d = 1'b0;
              hold_d    = '0;
              wsel_d    = 1'b0;
            end
          end
        end
      end
      WRITE: begin
        hold_d = hold_q + 1'b1;
        if (hold_end) begin
          ptr_d  = ptr_q + INS_ADDRESS'(ADDR_STEP);
          hold_d = '0;
          if (words_left_q != '0) begin
            s_ready_d = 1'b1;
          end else begin
            s_ready_d = 1'b0;
            enable_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset discards any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      wsel_q       <= 1'b0;
      words_left_q <= '0;
      ptr_q        <= '0;
      part_q       <= '0;
      word_a_q     <= '0;
      hold_q       <= '0;
      s_ready_q    <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      wsel_q       <= wsel_d;
      words_left_q <= words_left_d;
      ptr_q        <= ptr_d;
      part_q       <= part_d;
      word_a_q     <= word_a_d;
      hold_q       <= hold_d;
      s_ready_q    <= s_ready_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
    end
  end

  assign bus.s_ready          = s_ready_q;
  assign bus.enable_debug     = enable_q;
  assign bus.debug_address    = addr_q;
  assign bus.debug_inst_data1 = data1_q;
  assign bus.debug_inst_data2 = data2_q;
  assign bus.busy             = busy_q;
  assign bus.cpu_hold         = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random byte streams against a pair-write model.
module tb_imem_loader;
  localparam int          IA   = 9;
  localparam int          IW   = 32;
  localparam int          STEP = 2;
  localparam int          WC   = 2;
  localparam logic [31:0] PAD  = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  imem_loader_if #(.INS_ADDRESS(IA), .INS_W(IW)) bus ();

  imem_loader #(
    .INS_ADDRESS(IA), .INS_W(IW), .ADDR_STEP(STEP),
    .WRITE_CYCLES(WC), .PAD_WORD(PAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   wq[$];
  logic [IA-1:0] got_a[$];
  logic [31:0]   got_1[$];
  logic [31:0]   got_2[$];
  int done_cnt, done_cyc, wr_cyc, hold_len, hold_bad, stab_err, en_bad, link_bad;
  int last_acc;
  bit in_hold, prev_sready, prev_en, sready_seen, en_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the write port: a new pair appears when s_ready drops with
  // enable_debug high; that pair must then stay put for WC cycles.
  always @(negedge clk) begin
    if (rst) begin
      in_hold     = 1'b0;
      prev_sready = 1'b0;
      prev_en     = 1'b0;
    end else begin
      if (bus.enable_debug && prev_sready && !bus.s_ready) begin
        got_a.push_back(bus.debug_address);
        got_1.push_back(bus.debug_inst_data1);
        got_2.push_back(bus.debug_inst_data2);
        wr_cyc   = cyc;
        hold_len = 1;
        in_hold  = 1'b1;
      end else if (in_hold) begin
        if (bus.enable_debug && !bus.s_ready) begin
          hold_len++;
          if (bus.debug_address !== got_a[$] || bus.debug_inst_data1 !== got_1[$] ||
              bus.debug_inst_data2 !== got_2[$]) stab_err++;
        end else begin
          if (hold_len != WC) hold_bad++;
          in_hold = 1'b0;
        end
      end
      if (bus.enable_debug && !prev_en && !(prev_sready && !bus.s_ready)) en_bad++;
      if (bus.enable_debug && !bus.busy) en_bad++;
      if (bus.cpu_hold !== bus.busy) link_bad++;
      if (bus.s_ready) sready_seen = 1'b1;
      if (bus.enable_debug) en_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_sready = bus.s_ready;
      prev_en     = bus.enable_debug;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  guard;
    bit  sampled;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    forever begin
      @(negedge clk);
      sampled = bus.s_ready;
      @(posedge clk); #1;
      if (sampled) break;
      guard++;
      if (guard > 100) begin
        chk("byte_timeout", 1'b1, 1'b0);
        break;
      end
    end
    last_acc    = cyc;
    bus.s_valid = 1'b0;
  endtask

  task automatic clear_mon();
    got_a.delete(); got_1.delete(); got_2.delete();
    done_cnt = 0; done_cyc = 0; wr_cyc = 0; hold_bad = 0; stab_err = 0;
    en_bad = 0; link_bad = 0; sready_seen = 1'b0; en_seen = 1'b0;
  endtask

  task automatic fill_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic start_load(input int n, input int base);
    bus.num_words = (IA+1)'(n);
    bus.base_addr = IA'(base);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Run one load of the words in wq and compare against the pair model.
  task automatic run_load(input int n, input int base, input bit gaps, input bit mid_start);
    int            start_cyc, np;
    logic [31:0]   w, e2;
    logic [IA-1:0] ea;
    clear_mon();
    start_load(n, base);
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
      if (mid_start && i == 1) begin
        bus.num_words = (IA+1)'(1);
        bus.base_addr = IA'(base + 77);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    for (int k = 0; k < 40 && done_cnt == 0; k++) @(negedge clk);
    chk("done_seen", done_cnt > 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    np = (n + 1) / 2;
    chk("write_count", got_a.size(), np);
    for (int p = 0; p < np && p < got_a.size(); p++) begin
      ea = IA'(base + STEP * p);
      e2 = (2 * p + 1 < n) ? wq[2*p+1] : PAD;
      chk("wr_addr", got_a[p], ea);
      chk("wr_data1", got_1[p], wq[2*p]);
      chk("wr_data2", got_2[p], e2);
    end
    chk("done_pulses", done_cnt, 1);
    if (n == 0) begin
      chk("done_lat_empty", done_cyc - start_cyc, 0);
      chk("s_ready_empty", sready_seen, 1'b0);
      chk("enable_empty", en_seen, 1'b0);
    end else begin
      chk("done_latency", done_cyc - last_acc, WC);
      chk("pair_latency", wr_cyc - last_acc, 0);
    end
    chk("enable_after", bus.enable_debug, 1'b0);
    chk("busy_after", bus.busy, 1'b0);
    chk("s_ready_after", bus.s_ready, 1'b0);
    chk("hold_length", hold_bad, 0);
    chk("hold_stable", stab_err, 0);
    chk("enable_order", en_bad, 0);
    chk("cpu_hold_link", link_bad, 0);
    chk("addr_known", $isunknown(bus.debug_address), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.num_words = '0; bus.base_addr = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    clear_mon();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_enable", bus.enable_debug, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_addr", bus.debug_address, '0);
    chk("rst_data1", bus.debug_inst_data1, '0);
    chk("rst_data2", bus.debug_inst_data2, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    wq = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
    run_load(4, 'h010, 1'b0, 1'b0);
    chk("t1_pair1_d2", got_2.size() > 0 ? got_2[0] : 32'hx, 32'h00100093);
    chk("t1_pair2_addr", got_a.size() > 1 ? got_a[1] : 9'hx, 9'h012);

    fill_words(3);
    run_load(3, 'h000, 1'b0, 1'b0);

    wq.delete();
    run_load(0, 'h055, 1'b0, 1'b0);

    fill_words(4);
    run_load(4, 'h1FF, 1'b0, 1'b0);

    fill_words(8);
    run_load(8, 'h040, 1'b0, 1'b0);
    run_load(8, 'h040, 1'b1, 1'b1);

    // Reset in the middle of a 4-word load, after six bytes.
    fill_words(4);
    clear_mon();
    start_load(4, 'h020);
    for (int i = 0; i < 6; i++) send_byte(wq[i/4][8*(i%4) +: 8], 1'b0);
    chk("pre_rst_busy", bus.busy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_s_ready", bus.s_ready, 1'b0);
    chk("arst_enable", bus.enable_debug, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_cpu_hold", bus.cpu_hold, 1'b0);
    chk("arst_addr", bus.debug_address, '0);
    chk("arst_data1", bus.debug_inst_data1, '0);
    chk("arst_data2", bus.debug_inst_data2, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_words(2);
    run_load(2, 'h100, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 9);
      fill_words(n);
      run_load(n, $urandom_range(0, 511), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
